shift_seq: RTL

Multi-cycle sequencer for ARM register-specified shifts (`Rm, <shift> Rs`) in the EX stage. The single-cycle operand-2 generator handles only immediate shift amounts, so this block takes an Rm value and an Rs-supplied 8-bit amount. It shifts iteratively under a small FSM and returns the operand-2 value and shifter carry-out. While it runs, it asserts `busy`, which the hazard unit ORs into the pipeline freeze.

---
 rtl/shift_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Iterative sequencer for register-specified ARM shifts (LSL/LSR/ASR/ROR by Rs[7:0]).
// Optional macro SHIFT_SEQ_FAST_EN: up to 4 shift steps per SHIFT cycle.
module shift_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        shift_type,
    input  logic [7:0]        shift_amt,
    input  logic [DATA_W-1:0] rm_value,
    input  logic              carry_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              carry_out,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              carry_q, carry_d;
    logic [1:0]        type_q, type_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        steps;
    logic [5:0]        dec;
    logic [DATA_W:0]   stepped;

    // One-bit shift step; returns {carry, data}.
    function automatic logic [DATA_W:0] step1(input logic [1:0] t, input logic [DATA_W-1:0] d);
        case (t)
            ShLsl:   step1 = {d[DATA_W-1], d[DATA_W-2:0], 1'b0};
            ShLsr:   step1 = {d[0], 1'b0, d[DATA_W-1:1]};
            ShAsr:   step1 = {d[0], d[DATA_W-1], d[DATA_W-1:1]};
            default: step1 = {d[0], d[0], d[DATA_W-1:1]};
        endcase
    endfunction

    always_comb begin
        steps = 6'd0;
        case (shift_type)
            ShLsl, ShLsr: steps = (shift_amt > 8'd33) ? 6'd33 : shift_amt[5:0];
            ShAsr:        steps = (shift_amt > 8'd32) ? 6'd32 : shift_amt[5:0];
            default:      steps = {1'b0, shift_amt[4:0]};
        endcase
    end

`ifdef SHIFT_SEQ_FAST_EN
    always_comb begin
        stepped = {carry_q, data_q};
        for (int i = 0; i < 4; i++) begin
            if (cnt_q > 6'(i)) begin
                stepped = step1(type_q, stepped[DATA_W-1:0]);
            end
        end
        dec = (cnt_q > 6'd4) ? 6'd4 : cnt_q;
    end
`else
    always_comb begin
        stepped = step1(type_q, data_q);
        dec     = 6'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d  = rm_value;
                        type_d  = shift_type;
                        cnt_d   = steps;
                        // ROR by a non-zero multiple of 32: value unchanged, carry is the MSB.
                        carry_d = (shift_type == 2'b11 && shift_amt != 8'd0 &&
                                   shift_amt[4:0] == 5'd0) ? rm_value[DATA_W-1] : carry_in;
                        state_d = (steps != 6'd0) ? StShift : StDone;
                    end
                end
                StShift: begin
                    {carry_d, data_d} = stepped;
                    cnt_d = cnt_q - dec;
                    if (cnt_q == dec) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            carry_q <= 1'b0;
            type_q  <= 2'b00;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign val2      = data_q;
    assign carry_out = carry_q;

endmodule
